// File: rtl/dmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the data-memory responder
// Rev 1.0
// ----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  localparam int unsigned c_LATENCY_DEF   = 4;
  localparam int unsigned c_BURST_LEN_DEF = 8;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned f_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_delay_line : DEPTH-stage shift register with a resettable valid bit
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) r_valid <= 1'b0;
        else     r_valid <= i_valid;
        r_data <= i_data;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) r_valid <= 1'b0;
        else     r_valid <= g_stage[gi-1].r_valid;
        r_data <= g_stage[gi-1].r_data;
      end
    end
  end

  assign o_valid = g_stage[DEPTH-1].r_valid;
  assign o_data  = g_stage[DEPTH-1].r_data;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder : fixed-latency pipelined word memory with aligned burst reads
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH_W   = 10,
  parameter int unsigned LATENCY   = c_LATENCY_DEF,
  parameter int unsigned BURST_LEN = c_BURST_LEN_DEF,
  parameter string       INIT_FILE = "",
  localparam int unsigned IDX_W    = f_width(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [IDX_W-1:0]  data_idx,
  output logic              busy
);

  localparam int unsigned        c_WORDS     = 2 ** DEPTH_W;
  localparam logic [DEPTH_W-1:0] c_BEAT_MASK = DEPTH_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]   c_LAST_BEAT = IDX_W'(BURST_LEN - 1);
  localparam logic               c_HAS_BURST = (BURST_LEN > 1);

  // The array image, when given, is preloaded by the memory wrapper or loader.
  if (INIT_FILE != "") begin : g_init_hook
  end

  logic [DATA_W-1:0]  r_mem [c_WORDS];
  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DEPTH_W-1:0] r_base, w_base_nxt;

  logic [DEPTH_W-1:0] w_word;
  logic               w_accept;
  logic               w_iss_valid;
  logic [DEPTH_W-1:0] w_iss_word;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_dl_valid;
  logic [IDX_W+DATA_W-1:0] w_dl_data;
  logic               w_unused_addr;

  assign w_word        = addr[DEPTH_W:1];
  assign w_unused_addr = ^addr;
  assign w_accept      = enable && (r_state == S_IDLE);
  assign busy          = (r_state == S_BURST);

  always_ff @(posedge clk) begin
    if (!rst && w_accept && wr) r_mem[w_word] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
    r_base <= w_base_nxt;
  end

  // Beat 0 of a burst issues on the accepting edge; later beats come from the counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_base_nxt  = r_base;
    w_iss_valid = 1'b0;
    w_iss_word  = w_word;
    w_iss_idx   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !wr) begin
          w_iss_valid = 1'b1;
          if (burst && c_HAS_BURST) begin
            w_iss_word  = w_word & ~c_BEAT_MASK;
            w_base_nxt  = w_word & ~c_BEAT_MASK;
            w_cnt_nxt   = IDX_W'(1);
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        w_iss_valid = 1'b1;
        w_iss_word  = r_base | DEPTH_W'(r_cnt);
        w_iss_idx   = r_cnt;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == c_LAST_BEAT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  dmem_delay_line #(
    .WIDTH (IDX_W + DATA_W),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_iss_valid),
    .i_data  ({w_iss_idx, r_mem[w_iss_word]}),
    .o_valid (w_dl_valid),
    .o_data  (w_dl_data)
  );

  assign data_valid = w_dl_valid;
  assign data_out   = w_dl_valid ? w_dl_data[DATA_W-1:0] : '0;
  assign data_idx   = w_dl_valid ? w_dl_data[IDX_W+DATA_W-1:DATA_W] : '0;

endmodule
`default_nettype wire
